sm_result_fifo: RTL and testbench

//  Downstream stage of the 3-beat sum state machine (sm_dut).
//  - Captures each 7-bit sum on its 1-cycle o_dval pulse.
//  - Buffers sums in a small FIFO and presents them to a consumer over a valid/ready handshake.
//  - The producer has no backpressure, so the FIFO absorbs bursts.
//  - Overflow (push while full, no pop) drops the sample and is flagged.

---
 rtl/sm_result_fifo.sv | 139 +++++++++++++
 tb/tb_sm_result_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm_result_fifo.sv
// sm_result_fifo
//   Result buffer behind the 3-beat sum state machine. Captures each sum on its
//   one-cycle i_dval pulse, holds up to DEPTH entries and hands them to a
//   consumer over a valid/ready handshake. The producer cannot be stalled, so a
//   sample arriving while full (and not popping) is dropped and flagged.
//
// Ports
//   clk     in   clock, all state on posedge
//   rst     in   synchronous active-low reset
//   i_dval  in   producer sum valid (1-cycle pulse)
//   i       in   producer sum [DW-1:0]
//   i_rdy   in   consumer ready
//   o_dval  out  head entry valid (FIFO non-empty)
//   o       out  head entry data [DW-1:0]
//   o_cnt   out  occupancy 0..DEPTH [AW:0]
//   o_full  out  o_cnt == DEPTH
//   o_ovf   out  sticky overflow flag
//   o_drop  out  saturating drop count [7:0] (only with SM_RESULT_FIFO_DROPCNT_EN)
//
// Configuration
//   SM_RESULT_FIFO_DROPCNT_EN  when defined, adds o_drop and derives o_ovf from it.

module sm_result_fifo #(
   parameter int unsigned DW    = 7,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_dval,
   input  logic [DW-1:0] i,
   input  logic          i_rdy,
   output logic          o_dval,
   output logic [DW-1:0] o,
   output logic [AW:0]   o_cnt,
   output logic          o_full,
`ifdef SM_RESULT_FIFO_DROPCNT_EN
   output logic [7:0]    o_drop,
`endif
   output logic          o_ovf
);

   localparam logic [AW:0]   CntFull = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CntOne  = (AW+1)'(1);
   localparam logic [AW-1:0] PtrOne  = AW'(1);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          pop, push, drop;

   // Status comes from registered state only; no comb path from i_dval/i_rdy.
   assign o_dval = (cnt_q != '0);
   assign o_full = (cnt_q == CntFull);
   assign o_cnt  = cnt_q;
   assign o      = mem_q[rd_ptr_q];

   assign pop  = o_dval & i_rdy;
   // A pop frees the slot this cycle, so full + pop still accepts the push.
   assign push = i_dval & (~o_full | pop);
   assign drop = i_dval & o_full & ~pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = i;
         wr_ptr_d        = wr_ptr_q + PtrOne;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrOne;
      end
      if (push && !pop) begin
         cnt_d = cnt_q + CntOne;
      end else if (pop && !push) begin
         cnt_d = cnt_q - CntOne;
      end
   end

   // Storage needs no reset; entries are only visible through cnt_q.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef SM_RESULT_FIFO_DROPCNT_EN
   logic [7:0] drop_q, drop_d;

   always_comb begin
      drop_d = drop_q;
      if (drop && (drop_q != 8'hff)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign o_drop = drop_q;
   assign o_ovf  = (drop_q != '0);
`else
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q | drop;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign o_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sm_result_fifo.sv
// Self-checking bench for sm_result_fifo: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expected values.

module tb_sm_result_fifo;

   localparam int DW    = 7;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_dval;
   logic [DW-1:0] i;
   logic          i_rdy;
   logic          o_dval;
   logic [DW-1:0] o;
   logic [AW:0]   o_cnt;
   logic          o_full;
   logic          o_ovf;
`ifdef SM_RESULT_FIFO_DROPCNT_EN
   logic [7:0]    o_drop;
`endif

   sm_result_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .i_dval (i_dval),
      .i      (i),
      .i_rdy  (i_rdy),
      .o_dval (o_dval),
      .o      (o),
      .o_cnt  (o_cnt),
      .o_full (o_full),
`ifdef SM_RESULT_FIFO_DROPCNT_EN
      .o_drop (o_drop),
`endif
      .o_ovf  (o_ovf)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue with a drop counter.
   logic [DW-1:0] mq[$];
   int            m_drops = 0;
   bit            check_en = 1'b0;

   always @(posedge clk) begin
      bit did_pop;
      bit was_full;
      if (!rst) begin
         mq.delete();
         m_drops = 0;
      end else begin
         was_full = (mq.size() == DEPTH);
         did_pop  = (mq.size() > 0) && i_rdy;
         if (did_pop) void'(mq.pop_front());
         if (i_dval) begin
            if (was_full && !did_pop) begin
               if (m_drops < 255) m_drops++;
            end else begin
               mq.push_back(i);
            end
         end
      end
   end

   // Compare process: checks outputs mid-cycle and logs accepted pops.
   logic [DW-1:0] popped[$];

   always @(negedge clk) begin
      if (check_en) begin
         check("model_dval", {31'd0, o_dval}, {31'd0, mq.size() != 0});
         check("model_cnt",  {29'd0, o_cnt}, mq.size());
         check("model_full", {31'd0, o_full}, {31'd0, mq.size() == DEPTH});
         check("model_ovf",  {31'd0, o_ovf}, {31'd0, m_drops != 0});
`ifdef SM_RESULT_FIFO_DROPCNT_EN
         check("model_drop", {24'd0, o_drop}, m_drops);
`endif
         if (mq.size() != 0) check("model_data", {25'd0, o}, {25'd0, mq[0]});
         if (o_dval && i_rdy) popped.push_back(o);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      i_dval = 1'b1;
      i      = d;
      step();
      i_dval = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   task automatic check_popped(input string name, input int exp[$]);
      check({name, "_len"}, popped.size(), exp.size());
      for (int k = 0; k < exp.size() && k < popped.size(); k++) begin
         check(name, {25'd0, popped[k]}, exp[k]);
      end
   endtask

   initial begin
      // 1: reset held two cycles with a pending push
      rst    = 1'b0;
      i_dval = 1'b1;
      i      = 7'h55;
      i_rdy  = 1'b0;
      step();
      check_en = 1'b1;
      step();
      rst    = 1'b1;
      i_dval = 1'b0;
      check("rst_dval", {31'd0, o_dval}, 0);
      check("rst_cnt",  {29'd0, o_cnt}, 0);
      check("rst_ovf",  {31'd0, o_ovf}, 0);
      step();
      check("rst_cnt_after", {29'd0, o_cnt}, 0);

      // 2: single beat, 1-cycle latency
      i_rdy = 1'b1;
      push(7'd42);
      check("single_dval", {31'd0, o_dval}, 1);
      check("single_data", {25'd0, o}, 42);
      step();
      check("single_cnt", {29'd0, o_cnt}, 0);

      // 3: fill to full
      i_rdy = 1'b0;
      push(7'd10);
      push(7'd20);
      push(7'd30);
      push(7'd40);
      check("fill_full", {31'd0, o_full}, 1);
      check("fill_cnt",  {29'd0, o_cnt}, 4);
      step();
      check("stall_data", {25'd0, o}, 10);

      // 4: overflow drops 99, then drain
      push(7'd99);
      check("ovf_flag", {31'd0, o_ovf}, 1);
      check("ovf_cnt",  {29'd0, o_cnt}, 4);
`ifdef SM_RESULT_FIFO_DROPCNT_EN
      check("ovf_drop", {24'd0, o_drop}, 1);
`endif
      popped.delete();
      i_rdy = 1'b1;
      repeat (4) step();
      check_popped("drain", '{10, 20, 30, 40});
      check("drain_cnt", {29'd0, o_cnt}, 0);
      check("ovf_sticky", {31'd0, o_ovf}, 1);

      // 5: full + simultaneous push/pop
      do_reset();
      check("rst2_ovf", {31'd0, o_ovf}, 0);
      i_rdy = 1'b0;
      push(7'd1);
      push(7'd2);
      push(7'd3);
      push(7'd4);
      popped.delete();
      i_rdy = 1'b1;
      push(7'd77);
      check("fpp_cnt", {29'd0, o_cnt}, 4);
      check("fpp_ovf", {31'd0, o_ovf}, 0);
      repeat (4) step();
      check_popped("fpp_order", '{1, 2, 3, 4, 77});

      // 6: mid-operation reset flushes entries
      i_rdy = 1'b0;
      push(7'd11);
      push(7'd12);
      push(7'd13);
      check("mid_cnt_pre", {29'd0, o_cnt}, 3);
      rst    = 1'b0;
      i_dval = 1'b1;
      i      = 7'd9;
      step();
      rst    = 1'b1;
      i_dval = 1'b0;
      check("mid_cnt",  {29'd0, o_cnt}, 0);
      check("mid_dval", {31'd0, o_dval}, 0);
      popped.delete();
      push(7'd5);
      i_rdy = 1'b1;
      step();
      check_popped("mid_first", '{5});

      // Mixed burst: uneven push/pop rates, overflow included; model-checked.
      for (int k = 0; k < 40; k++) begin
         i_dval = (k % 3) != 0;
         i      = 7'(k + 100);
         i_rdy  = (k % 4) == 0;
         step();
      end
      i_dval = 1'b0;
      i_rdy  = 1'b1;
      repeat (6) step();
      check("burst_empty", {29'd0, o_cnt}, 0);

      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
